// File: rtl/i2c_recovery_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | i2c_recovery_ctrl: checks for a stuck I2C bus, paces and supervises the  |
// | bus recovery engine, retries, and owns the pad mux select.               |
// | Option: I2C_RECOVERY_AUTOSTART_EN runs one sequence after every reset.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module i2c_recovery_ctrl #(
    parameter int CE_DIV        = 250,
    parameter int CHECK_TICKS   = 16,
    parameter int MAX_CLOCKS    = 9,
    parameter int RETRIES       = 3,
    parameter int HOLDOFF_TICKS = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req,
    input  logic                           sda,
    input  logic                           rec_scl,
    input  logic                           rec_sda,
    output logic                           ce,
    output logic                           start,
    output logic                           mux_sel,
    output logic                           busy,
    output logic                           done,
    output logic                           fail,
    output logic [$clog2(RETRIES+1)-1:0]   attempts
);

    localparam int c_pw   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam int c_tmax = (CHECK_TICKS > HOLDOFF_TICKS) ? CHECK_TICKS : HOLDOFF_TICKS;
    localparam int c_tw   = $clog2(c_tmax + 1);
    localparam int c_ew   = $clog2(MAX_CLOCKS + 2);
    localparam int c_aw   = $clog2(RETRIES + 1);

    localparam logic [c_pw-1:0] c_ce_last    = c_pw'(CE_DIV - 1);
    localparam logic [c_tw-1:0] c_chk_last   = c_tw'(CHECK_TICKS - 1);
    localparam logic [c_tw-1:0] c_hold_last  = c_tw'(HOLDOFF_TICKS - 1);
    localparam logic [c_ew-1:0] c_edge_abort = c_ew'(MAX_CLOCKS + 1);
    localparam logic [c_aw-1:0] c_retries    = c_aw'(RETRIES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_RECOVER = 3'd2,
        S_HOLDOFF = 3'd3,
        S_DONE    = 3'd4,
        S_FAIL    = 3'd5
    } state_t;

    state_t          r_state;
    logic [c_pw-1:0] r_presc;
    logic [c_tw-1:0] r_tick;
    logic [c_ew-1:0] r_edge;
    logic            r_strobe;
    logic            r_scl_q;

    logic            w_req;
    logic            w_rise;
    logic            w_can_retry;
    logic [c_ew-1:0] w_edge_nxt;

`ifdef I2C_RECOVERY_AUTOSTART_EN
    logic r_autostart;
    assign w_req = req | r_autostart;
`else
    assign w_req = req;
`endif

    assign w_rise      = rec_scl & ~r_scl_q;
    assign w_can_retry = (attempts < c_retries);
    // Edge count saturates at the abort value so it cannot wrap after a strobe.
    assign w_edge_nxt  = (w_rise && (r_edge != c_edge_abort)) ? r_edge + 1'b1 : r_edge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            r_tick   <= '0;
            r_edge   <= '0;
            r_strobe <= 1'b0;
            r_scl_q  <= 1'b0;
            ce       <= 1'b0;
            start    <= 1'b0;
            mux_sel  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fail     <= 1'b0;
            attempts <= '0;
`ifdef I2C_RECOVERY_AUTOSTART_EN
            r_autostart <= 1'b1;
`endif
        end else begin
            r_scl_q <= rec_scl;
            start   <= 1'b0;
            ce      <= 1'b0;
`ifdef I2C_RECOVERY_AUTOSTART_EN
            r_autostart <= 1'b0;
`endif
            if (busy) begin
                if (r_presc == c_ce_last) begin
                    r_presc <= '0;
                    ce      <= 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            // Every state change below restarts the prescaler and drops a coincident tick.
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        done     <= 1'b0;
                        fail     <= 1'b0;
                        attempts <= '0;
                        busy     <= 1'b1;
                        r_tick   <= '0;
                        r_presc  <= '0;
                        r_state  <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (ce) begin
                        if (sda) begin
                            r_presc <= '0;
                            ce      <= 1'b0;
                            r_state <= S_DONE;
                        end else if (r_tick == c_chk_last) begin
                            r_presc <= '0;
                            ce      <= 1'b0;
                            if (w_can_retry) begin
                                start    <= 1'b1;
                                mux_sel  <= 1'b1;
                                r_edge   <= '0;
                                r_strobe <= 1'b0;
                                attempts <= attempts + 1'b1;
                                r_state  <= S_RECOVER;
                            end else begin
                                r_state <= S_FAIL;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end

                S_RECOVER: begin
                    r_edge <= w_edge_nxt;
                    if (rec_scl && !rec_sda) begin
                        r_strobe <= 1'b1;
                    end
                    if (r_strobe && rec_sda) begin
                        mux_sel <= 1'b0;
                        r_tick  <= '0;
                        r_presc <= '0;
                        ce      <= 1'b0;
                        r_state <= S_CHECK;
                    end else if (!r_strobe && (w_edge_nxt == c_edge_abort)) begin
                        mux_sel <= 1'b0;
                        r_tick  <= '0;
                        r_presc <= '0;
                        ce      <= 1'b0;
                        r_state <= S_HOLDOFF;
                    end
                end

                S_HOLDOFF: begin
                    if (ce) begin
                        if (r_tick == c_hold_last) begin
                            r_tick  <= '0;
                            r_presc <= '0;
                            ce      <= 1'b0;
                            r_state <= (attempts == c_retries) ? S_FAIL : S_CHECK;
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_presc <= '0;
                    ce      <= 1'b0;
                    r_state <= S_IDLE;
                end

                S_FAIL: begin
                    fail    <= 1'b1;
                    busy    <= 1'b0;
                    mux_sel <= 1'b0;
                    r_presc <= '0;
                    ce      <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_recovery_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_i2c_recovery_ctrl: directed bench with a behavioural recovery engine. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_i2c_recovery_ctrl;

    localparam int CE_DIV        = 4;
    localparam int CHECK_TICKS   = 4;
    localparam int MAX_CLOCKS    = 9;
    localparam int RETRIES       = 3;
    localparam int HOLDOFF_TICKS = 8;
    localparam int TIMEOUT       = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic       sda;
    logic       rec_scl = 1'b1;
    logic       rec_sda = 1'b1;
    logic       ce, start, mux_sel, busy, done, fail;
    logic [1:0] attempts;

    // Scenario knobs (written by the stimulus process only)
    logic stuck_cfg   = 1'b1;
    int   clear_after = 3;
    int   run_id      = 0;

    // Engine-owned state and statistics
    logic released    = 1'b0;
    logic eng_active  = 1'b0;
    logic eng_stop    = 1'b0;
    int   eng_step    = 0;
    int   eng_edges   = 0;
    int   seen_id     = 0;
    int   cyc         = 0;
    int   n_starts    = 0;
    int   n_aborts    = 0;
    int   min_edges   = 1000;
    int   max_edges   = 0;
    int   min_gap     = 1000000;
    int   last_start  = -1;

    int checks = 0;
    int errors = 0;

    assign sda = ~stuck_cfg | released;

    i2c_recovery_ctrl #(
        .CE_DIV        (CE_DIV),
        .CHECK_TICKS   (CHECK_TICKS),
        .MAX_CLOCKS    (MAX_CLOCKS),
        .RETRIES       (RETRIES),
        .HOLDOFF_TICKS (HOLDOFF_TICKS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .sda      (sda),
        .rec_scl  (rec_scl),
        .rec_sda  (rec_sda),
        .ce       (ce),
        .start    (start),
        .mux_sel  (mux_sel),
        .busy     (busy),
        .done     (done),
        .fail     (fail),
        .attempts (attempts)
    );

    always #5 clk = ~clk;

    // Engine: toggles SCL per ce; after clear_after rising edges the bus frees
    // and it issues a STOP (SCL high with SDA low, then SDA high).
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (run_id != seen_id) begin
            seen_id    = run_id;
            released   = 1'b0;
            n_starts   = 0;
            n_aborts   = 0;
            min_edges  = 1000;
            max_edges  = 0;
            min_gap    = 1000000;
            last_start = -1;
        end
        if (!rst_n) begin
            eng_active = 1'b0;
            rec_scl    = 1'b1;
            rec_sda    = 1'b1;
        end else if (start) begin
            n_starts = n_starts + 1;
            if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
            last_start = cyc;
            eng_active = 1'b1;
            eng_stop   = 1'b0;
            eng_step   = 0;
            eng_edges  = 0;
            rec_scl    = 1'b1;
            rec_sda    = 1'b1;
        end else if (eng_active && !mux_sel) begin
            n_aborts = n_aborts + 1;
            if (eng_edges < min_edges) min_edges = eng_edges;
            if (eng_edges > max_edges) max_edges = eng_edges;
            eng_active = 1'b0;
            rec_scl    = 1'b1;
            rec_sda    = 1'b1;
        end else if (eng_active && ce) begin
            if (!eng_stop) begin
                rec_scl = ~rec_scl;
                if (rec_scl) begin
                    eng_edges = eng_edges + 1;
                    if (clear_after > 0 && eng_edges == clear_after) begin
                        released = 1'b1;
                        eng_stop = 1'b1;
                    end
                end
            end else begin
                case (eng_step)
                    0:       begin rec_scl = 1'b0; rec_sda = 1'b0; end
                    1:       begin rec_scl = 1'b1; eng_edges = eng_edges + 1; end
                    default: begin rec_sda = 1'b1; eng_active = 1'b0; end
                endcase
                eng_step = eng_step + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic new_run(input logic stuck, input int clr);
        run_id      = run_id + 1;
        stuck_cfg   = stuck;
        clear_after = clr;
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_req();
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < TIMEOUT) begin
            @(negedge clk);
            n = n + 1;
        end
        check({name, "_timeout"}, (n < TIMEOUT) ? 1 : 0, 1);
    endtask

    task automatic wait_mux(input string name);
        int n;
        n = 0;
        while (mux_sel !== 1'b1 && n < TIMEOUT) begin
            @(negedge clk);
            n = n + 1;
        end
        check({name, "_mux_timeout"}, (n < TIMEOUT) ? 1 : 0, 1);
    endtask

    typedef struct {
        string name;
        logic  stuck;
        int    clr;
        logic  exp_done;
        logic  exp_fail;
        int    exp_att;
        int    exp_starts;
        int    exp_aborts;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"free",      1'b0, 0, 1'b1, 1'b0, 0, 0, 0};
        vecs[1] = '{"clear3",    1'b1, 3, 1'b1, 1'b0, 1, 1, 0};
        vecs[2] = '{"clear1",    1'b1, 1, 1'b1, 1'b0, 1, 1, 0};
        vecs[3] = '{"clear8",    1'b1, 8, 1'b1, 1'b0, 1, 1, 0};
        vecs[4] = '{"permanent", 1'b1, 0, 1'b0, 1'b1, 3, 3, 3};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ce",       ce,       0);
        check("rst_start",    start,    0);
        check("rst_mux_sel",  mux_sel,  0);
        check("rst_busy",     busy,     0);
        check("rst_done",     done,     0);
        check("rst_fail",     fail,     0);
        check("rst_attempts", attempts, 0);

        // Behaviour right after reset release, bus stuck, engine clears after 3
        rst_n = 1'b1;
        @(negedge clk);
`ifdef I2C_RECOVERY_AUTOSTART_EN
        check("auto_busy_first", busy, 1);
        wait_idle("auto");
        check("auto_done",     done,     1);
        check("auto_attempts", attempts, 1);
        check("auto_starts",   n_starts, 1);
`else
        check("noauto_busy_first", busy, 0);
        repeat (40) @(negedge clk);
        check("noauto_busy", busy,     0);
        check("noauto_starts", n_starts, 0);
`endif

        // Bus free: exact latency to done
        new_run(1'b0, 0);
        pulse_req();
        repeat (5) @(negedge clk);
        check("free_done_early", done, 0);
        check("free_busy_early", busy, 1);
        @(negedge clk);
        check("free_done",     done,     1);
        check("free_busy",     busy,     0);
        check("free_attempts", attempts, 0);
        check("free_starts",   n_starts, 0);

        // Table-driven scenarios
        for (int i = 0; i < 5; i++) begin
            new_run(vecs[i].stuck, vecs[i].clr);
            pulse_req();
            check({vecs[i].name, "_busy"}, busy, 1);
            wait_idle(vecs[i].name);
            check({vecs[i].name, "_done"},     done,     vecs[i].exp_done);
            check({vecs[i].name, "_fail"},     fail,     vecs[i].exp_fail);
            check({vecs[i].name, "_attempts"}, attempts, vecs[i].exp_att);
            check({vecs[i].name, "_starts"},   n_starts, vecs[i].exp_starts);
            check({vecs[i].name, "_aborts"},   n_aborts, vecs[i].exp_aborts);
            check({vecs[i].name, "_mux_sel"},  mux_sel,  0);
            if (vecs[i].exp_aborts > 0) begin
                check({vecs[i].name, "_min_edges"}, min_edges, MAX_CLOCKS + 1);
                check({vecs[i].name, "_max_edges"}, max_edges, MAX_CLOCKS + 1);
            end
            if (vecs[i].exp_starts > 1) begin
                check({vecs[i].name, "_gap_ok"},
                      (min_gap >= HOLDOFF_TICKS * CE_DIV) ? 1 : 0, 1);
            end
        end

        // req while busy is ignored in CHECK and in RECOVER
        new_run(1'b1, 3);
        pulse_req();
        repeat (3) @(negedge clk);
        pulse_req();
        wait_mux("reqbusy");
        check("reqbusy_att_in_recover", attempts, 1);
        repeat (2) @(negedge clk);
        pulse_req();
        wait_idle("reqbusy");
        check("reqbusy_done",     done,     1);
        check("reqbusy_fail",     fail,     0);
        check("reqbusy_attempts", attempts, 1);
        check("reqbusy_starts",   n_starts, 1);

        // Asynchronous reset in the middle of RECOVER
        new_run(1'b1, 0);
        pulse_req();
        wait_mux("midrst");
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_mux_sel",  mux_sel,  0);
        check("midrst_busy",     busy,     0);
        check("midrst_ce",       ce,       0);
        check("midrst_start",    start,    0);
        check("midrst_attempts", attempts, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
`ifndef I2C_RECOVERY_AUTOSTART_EN
        check("midrst_idle_busy", busy, 0);
`endif
        wait_idle("midrst_settle");

        // Sequence after reset still works
        new_run(1'b0, 0);
        pulse_req();
        wait_idle("post_rst");
        check("post_rst_done",     done,     1);
        check("post_rst_fail",     fail,     0);
        check("post_rst_attempts", attempts, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_recovery_ctrl.md
Name: i2c_recovery_ctrl

Overview:
- Sequencer that sits directly upstream of the I2C bus recovery engine.
- Decides whether the bus is stuck (SDA held low), paces the engine with its clock-enable, and pulses its start input.
- Supervises the engine's SCL/SDA outputs to detect completion or a runaway, retries a bounded number of times, and drives the pad mux select that hands the I2C pins to the engine.

Parameters:
CE_DIV, 250, clk cycles per ce tick (two ticks per SCL period; 50 MHz clk gives 100 kHz SCL)
CHECK_TICKS, 16, consecutive ce ticks SDA must read low to declare the bus stuck
MAX_CLOCKS, 9, SCL rising edges allowed per attempt before abort
RETRIES, 3, recovery attempts before giving up
HOLDOFF_TICKS, 64, ce ticks idle between a failed attempt and the next check

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  1  single-cycle request to check/recover the bus
sda  in  1  pad SDA, already synchronised to clk
rec_scl  in  1  SCL output of recovery engine
rec_sda  in  1  SDA output of recovery engine
ce  out  1  clock-enable tick to engine, one clk cycle wide
start  out  1  start pulse to engine, one clk cycle wide
mux_sel  out  1  1 = engine drives the pads, 0 = normal I2C master drives them
busy  out  1  sequence in progress
done  out  1  sticky: last sequence ended with bus free
fail  out  1  sticky: last sequence exhausted RETRIES
attempts  out  $clog2(RETRIES+1)  attempts used in the current/last sequence

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; prescaler, tick, edge and attempt counters 0. Takes effect immediately mid-sequence, so mux_sel drops without waiting for clk.
- Prescaler:
  - Runs only while busy.
  - ce = 1 for one cycle when the prescaler reaches CE_DIV-1, then wraps to 0.
  - Cleared in the cycle a state is entered, so the first ce after any state change comes exactly CE_DIV cycles later.
- IDLE: busy=0. On req: done<=0, fail<=0, attempts<=0, go CHECK.
- CHECK (busy=1, mux_sel=0):
  - sample sda on each ce; sda=1 on any sample -> DONE.
  - CHECK_TICKS consecutive low samples -> RECOVER.
- RECOVER:
  - On entry: start=1 for that single cycle, mux_sel=1, edge counter 0, strobe flag 0, attempts incremented.
  - Rising edge of rec_scl (against registered previous value) increments the edge counter.
  - Strobe flag set when rec_scl=1 and rec_sda=0.
  - Strobe flag set and rec_sda=1 -> mux_sel<=0, go CHECK to re-verify.
  - Edge counter reaching MAX_CLOCKS+1 with no strobe -> mux_sel<=0, go HOLDOFF.
  - If both conditions occur in the same cycle, the strobe completion wins.
- HOLDOFF: count HOLDOFF_TICKS ce ticks. Then: if attempts==RETRIES -> FAIL, else -> CHECK.
- Re-verify failure: CHECK entered after a completed attempt that again sees CHECK_TICKS lows goes to RECOVER only if attempts<RETRIES; otherwise -> FAIL.
- DONE: done<=1, busy<=0, -> IDLE. Takes one cycle.
- FAIL: fail<=1, busy<=0, mux_sel=0, -> IDLE. Takes one cycle.
- req while busy is ignored. req in the same cycle as DONE/FAIL is ignored.
- A new req in IDLE clears done/fail in the next cycle.
- attempts saturates at RETRIES and never wraps.
- mux_sel is registered and is never high outside RECOVER.

Optional Feature:
- Macro: I2C_RECOVERY_AUTOSTART_EN.
- Defined: the first clk edge after rst_n deasserts acts as an internal req, so one check/recover sequence runs automatically after every reset. External req behaves as before.
- Undefined: the block stays in IDLE until req; no sequence runs after reset.

Test Plan:
- Bus free: CE_DIV=4. req with sda=1 -> done=1 after 1 ce tick (~5 cycles); start never pulses; mux_sel stays 0; attempts=0.
- Stuck, clears on 3rd clock: sda=0, engine model releases sda after 3 rec_scl rising edges -> exactly one start pulse; mux_sel=1 until the strobe completes; re-check passes; done=1, attempts=1.
- Permanent stuck, RETRIES=3: sda tied 0, engine never strobes -> 3 start pulses spaced by ≥ HOLDOFF_TICKS*CE_DIV cycles; abort after the 10th rec_scl edge each time; fail=1, done=0, attempts=3, mux_sel=0.
- Reset mid-RECOVER: assert rst_n=0 while mux_sel=1 -> mux_sel, busy, ce and start are 0 before the next clk edge; all state and counters are cleared.
- req during busy: pulse req in CHECK and again in RECOVER -> no restart, attempts unchanged, sequence ends normally.
- Autostart: with I2C_RECOVERY_AUTOSTART_EN and sda=0 at reset release -> busy=1 on the 1st cycle and a start pulse after CHECK_TICKS ce ticks, with no req. Without the macro -> busy stays 0.
